pipe_stall_ctrl: RTL and testbench

//  Central stall/flush sequencer for the 5-stage MIPS32 pipeline (IF, ID, EXE, MEM, WB).
//  - Detects load-use hazards between the ID operand reads and a load in EXE.
//  - Sequences the multi-cycle divider used by DIV/DIVU in EXE through a small FSM.
//  - Drives per-stage hold and bubble controls to the PC and to the pipeline registers.

---
 rtl/pipe_stall_ctrl.sv | 139 +++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 385 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, divider FSM,
// per-stage hold/bubble controls. Optional perf counter under STALL_PERF_CNT_EN.
// Ports: clk, rst (sync, active-high); ID read ports id_re1/id_ra1/id_re2/id_ra2;
//   EXE info exe_wreg/exe_wa/exe_mreg/exe_div_req; divider handshake div_done/div_start;
//   controls stall[4:0] (PC,IF/ID,ID/EXE,EXE/MEM,MEM/WB), flush_idexe, flush_exemem;
//   status busy, div_err, perf_stall[CNT_W-1:0].
module pipe_stall_ctrl #(
    parameter int DIV_TIMEOUT = 40,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_re1,
    input  logic [4:0]       id_ra1,
    input  logic             id_re2,
    input  logic [4:0]       id_ra2,
    input  logic             exe_wreg,
    input  logic [4:0]       exe_wa,
    input  logic             exe_mreg,
    input  logic             exe_div_req,
    input  logic             div_done,
    output logic             div_start,
    output logic [4:0]       stall,
    output logic             flush_idexe,
    output logic             flush_exemem,
    output logic             busy,
    output logic             div_err,
    output logic [CNT_W-1:0] perf_stall
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_DONE
    } state_t;

    // Hold PC, IF/ID and ID/EXE; bubble into EXE/MEM while the divider runs.
    localparam logic [4:0] HOLD_DIV  = 5'b00111;
    localparam logic [4:0] HOLD_LOAD = 5'b00011;
    localparam logic [7:0] CNT_LAST  = 8'(DIV_TIMEOUT - 1);

    state_t     state, state_nxt;
    logic [7:0] wait_cnt, wait_cnt_nxt;
    logic       load_use;

    assign load_use = exe_mreg & exe_wreg & (exe_wa != 5'd0) &
                      ((id_re1 & (id_ra1 == exe_wa)) |
                       (id_re2 & (id_ra2 == exe_wa)));

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            wait_cnt <= 8'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        div_start    = 1'b0;
        stall        = 5'b00000;
        flush_idexe  = 1'b0;
        flush_exemem = 1'b0;
        busy         = 1'b0;
        div_err      = 1'b0;
        unique case (state)
            S_IDLE: begin
                wait_cnt_nxt = 8'd0;
                if (exe_div_req) begin
                    state_nxt    = S_START;
                    stall        = HOLD_DIV;
                    flush_exemem = 1'b1;
                end else if (load_use) begin
                    stall       = HOLD_LOAD;
                    flush_idexe = 1'b1;
                end
            end
            S_START: begin
                busy         = 1'b1;
                div_start    = 1'b1;
                stall        = HOLD_DIV;
                flush_exemem = 1'b1;
                wait_cnt_nxt = 8'd0;
                state_nxt    = div_done ? S_DONE : S_WAIT;
            end
            S_WAIT: begin
                busy         = 1'b1;
                stall        = HOLD_DIV;
                flush_exemem = 1'b1;
                wait_cnt_nxt = wait_cnt + 8'd1;
                // A done arriving on the last allowed cycle is still a success.
                if (div_done) begin
                    state_nxt = S_DONE;
                end else if (wait_cnt >= CNT_LAST) begin
                    div_err   = 1'b1;
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                // The DIV itself is still in EXE; its request is not a new one.
                busy      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        // Nothing is launched or held while reset is asserted.
        if (rst) begin
            div_start    = 1'b0;
            stall        = 5'b00000;
            flush_idexe  = 1'b0;
            flush_exemem = 1'b0;
            busy         = 1'b0;
            div_err      = 1'b0;
        end
    end

`ifdef STALL_PERF_CNT_EN
    logic [CNT_W-1:0] perf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_q <= '0;
        end else if ((stall != 5'b00000) && (perf_q != {CNT_W{1'b1}})) begin
            perf_q <= perf_q + 1'b1;
        end
    end

    assign perf_stall = perf_q;
`else
    assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed self-checking bench for pipe_stall_ctrl (DIV_TIMEOUT=40, CNT_W=4).
// Inputs change on the falling edge; outputs are checked 1ns later.
module tb_pipe_stall_ctrl;

    logic       clk;
    logic       rst;
    logic       id_re1;
    logic [4:0] id_ra1;
    logic       id_re2;
    logic [4:0] id_ra2;
    logic       exe_wreg;
    logic [4:0] exe_wa;
    logic       exe_mreg;
    logic       exe_div_req;
    logic       div_done;
    logic       div_start;
    logic [4:0] stall;
    logic       flush_idexe;
    logic       flush_exemem;
    logic       busy;
    logic       div_err;
    logic [3:0] perf_stall;

    int errors = 0;
    int checks = 0;

`ifdef STALL_PERF_CNT_EN
    localparam logic [3:0] PERF_5  = 4'd5;
    localparam logic [3:0] PERF_20 = 4'd15;
`else
    localparam logic [3:0] PERF_5  = 4'd0;
    localparam logic [3:0] PERF_20 = 4'd0;
`endif

    pipe_stall_ctrl #(.DIV_TIMEOUT(40), .CNT_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_re1       (id_re1),
        .id_ra1       (id_ra1),
        .id_re2       (id_re2),
        .id_ra2       (id_ra2),
        .exe_wreg     (exe_wreg),
        .exe_wa       (exe_wa),
        .exe_mreg     (exe_mreg),
        .exe_div_req  (exe_div_req),
        .div_done     (div_done),
        .div_start    (div_start),
        .stall        (stall),
        .flush_idexe  (flush_idexe),
        .flush_exemem (flush_exemem),
        .busy         (busy),
        .div_err      (div_err),
        .perf_stall   (perf_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        id_re1      = 1'b0;
        id_ra1      = 5'd0;
        id_re2      = 1'b0;
        id_ra2      = 5'd0;
        exe_wreg    = 1'b0;
        exe_wa      = 5'd0;
        exe_mreg    = 1'b0;
        exe_div_req = 1'b0;
        div_done    = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if ({div_start, stall, flush_idexe, flush_exemem, busy, div_err} !== 10'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 0",
                     {div_start, stall, flush_idexe, flush_exemem, busy, div_err});
        end
        checks++;
        if (perf_stall !== 4'd0) begin
            errors++;
            $display("FAIL reset_perf: got %0d expected 0", perf_stall);
        end
    endtask

    task automatic test_load_use();
        @(negedge clk);
        exe_mreg = 1'b1; exe_wreg = 1'b1; exe_wa = 5'd5;
        id_re1 = 1'b1; id_ra1 = 5'd5;
        #1;
        checks++;
        if (stall !== 5'b00011 || flush_idexe !== 1'b1 || flush_exemem !== 1'b0) begin
            errors++;
            $display("FAIL load_use_ra1: stall=%b fi=%b fe=%b expected 00011 1 0",
                     stall, flush_idexe, flush_exemem);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL load_use_busy: got %b expected 0", busy);
        end
        @(negedge clk);
        exe_mreg = 1'b0;
        #1;
        checks++;
        if (stall !== 5'b00000 || flush_idexe !== 1'b0) begin
            errors++;
            $display("FAIL load_use_release: stall=%b fi=%b expected 00000 0",
                     stall, flush_idexe);
        end
        @(negedge clk);
        exe_mreg = 1'b1; exe_wa = 5'd9;
        id_re1 = 1'b1; id_ra1 = 5'd3;
        id_re2 = 1'b1; id_ra2 = 5'd9;
        #1;
        checks++;
        if (stall !== 5'b00011 || flush_idexe !== 1'b1) begin
            errors++;
            $display("FAIL load_use_ra2: stall=%b fi=%b expected 00011 1",
                     stall, flush_idexe);
        end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_no_hazard();
        @(negedge clk);
        exe_mreg = 1'b1; exe_wreg = 1'b1; exe_wa = 5'd0;
        id_re1 = 1'b1; id_ra1 = 5'd0;
        #1;
        checks++;
        if (stall !== 5'b00000 || flush_idexe !== 1'b0) begin
            errors++;
            $display("FAIL no_hazard_r0: stall=%b fi=%b expected 00000 0",
                     stall, flush_idexe);
        end
        @(negedge clk);
        exe_wa = 5'd5; id_re1 = 1'b0; id_ra1 = 5'd5;
        #1;
        checks++;
        if (stall !== 5'b00000 || flush_idexe !== 1'b0) begin
            errors++;
            $display("FAIL no_hazard_noread: stall=%b fi=%b expected 00000 0",
                     stall, flush_idexe);
        end
        @(negedge clk);
        id_re1 = 1'b1; exe_wreg = 1'b0;
        #1;
        checks++;
        if (stall !== 5'b00000 || flush_idexe !== 1'b0) begin
            errors++;
            $display("FAIL no_hazard_nowreg: stall=%b fi=%b expected 00000 0",
                     stall, flush_idexe);
        end
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic test_priority();
        @(negedge clk);
        exe_mreg = 1'b1; exe_wreg = 1'b1; exe_wa = 5'd7;
        id_re1 = 1'b1; id_ra1 = 5'd7;
        exe_div_req = 1'b1;
        #1;
        checks++;
        if (stall !== 5'b00111 || flush_idexe !== 1'b0 || flush_exemem !== 1'b1) begin
            errors++;
            $display("FAIL div_priority: stall=%b fi=%b fe=%b expected 00111 0 1",
                     stall, flush_idexe, flush_exemem);
        end
        do_reset();
    endtask

    task automatic test_div_normal();
        int n_stall = 0;
        int n_start = 0;
        int n_err   = 0;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            exe_div_req = (c <= 12);
            div_done    = (c == 11);
            #1;
            if (stall == 5'b00111) n_stall++;
            if (div_start) n_start++;
            if (div_err) n_err++;
            if (c == 12) begin
                checks++;
                if (stall !== 5'b00000 || busy !== 1'b1 || flush_exemem !== 1'b0) begin
                    errors++;
                    $display("FAIL div_done_state: stall=%b busy=%b fe=%b expected 00000 1 0",
                             stall, busy, flush_exemem);
                end
            end
            if (c == 13) begin
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL div_idle_busy: got %b expected 0", busy);
                end
            end
        end
        checks++;
        if (n_stall !== 12) begin
            errors++;
            $display("FAIL div_stall_cycles: got %0d expected 12", n_stall);
        end
        checks++;
        if (n_start !== 1) begin
            errors++;
            $display("FAIL div_start_count: got %0d expected 1", n_start);
        end
        checks++;
        if (n_err !== 0) begin
            errors++;
            $display("FAIL div_err_count_ok: got %0d expected 0", n_err);
        end
        clear_inputs();
    endtask

    task automatic test_div_fast();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            exe_div_req = (c <= 2);
            div_done    = (c == 1);
            #1;
            if (c == 1) begin
                checks++;
                if (div_start !== 1'b1 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL fast_start: ds=%b busy=%b expected 1 1", div_start, busy);
                end
            end
            if (c == 2) begin
                checks++;
                if (stall !== 5'b00000 || busy !== 1'b1 || div_start !== 1'b0) begin
                    errors++;
                    $display("FAIL fast_done: stall=%b busy=%b ds=%b expected 00000 1 0",
                             stall, busy, div_start);
                end
            end
            if (c == 3) begin
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL fast_idle: busy=%b expected 0", busy);
                end
            end
        end
        clear_inputs();
    endtask

    task automatic test_div_timeout();
        int n_err  = 0;
        int err_at = -1;
        for (int c = 0; c < 44; c++) begin
            @(negedge clk);
            exe_div_req = (c <= 42);
            #1;
            if (div_err) begin
                n_err++;
                err_at = c;
            end
            if (c == 42) begin
                checks++;
                if (stall !== 5'b00000 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL timeout_done: stall=%b busy=%b expected 00000 1",
                             stall, busy);
                end
            end
            if (c == 43) begin
                checks++;
                if (busy !== 1'b0 || stall !== 5'b00000) begin
                    errors++;
                    $display("FAIL timeout_idle: busy=%b stall=%b expected 0 00000",
                             busy, stall);
                end
            end
        end
        checks++;
        if (n_err !== 1) begin
            errors++;
            $display("FAIL timeout_err_count: got %0d expected 1", n_err);
        end
        checks++;
        if (err_at !== 41) begin
            errors++;
            $display("FAIL timeout_err_cycle: got %0d expected 41", err_at);
        end
        clear_inputs();
    endtask

    task automatic test_reset_in_wait();
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            exe_div_req = (c <= 4);
            rst         = (c == 4);
            div_done    = (c == 5);
            #1;
            if (c == 3) begin
                checks++;
                if (busy !== 1'b1 || stall !== 5'b00111) begin
                    errors++;
                    $display("FAIL rst_pre_wait: busy=%b stall=%b expected 1 00111",
                             busy, stall);
                end
            end
            if (c == 5) begin
                checks++;
                if (busy !== 1'b0 || stall !== 5'b00000 || div_start !== 1'b0) begin
                    errors++;
                    $display("FAIL rst_idle: busy=%b stall=%b ds=%b expected 0 00000 0",
                             busy, stall, div_start);
                end
            end
            if (c == 6) begin
                checks++;
                if (busy !== 1'b0 || div_err !== 1'b0) begin
                    errors++;
                    $display("FAIL rst_late_done: busy=%b err=%b expected 0 0",
                             busy, div_err);
                end
            end
        end
        rst = 1'b0;
        clear_inputs();
    endtask

    task automatic test_perf();
        do_reset();
        @(negedge clk);
        exe_mreg = 1'b1; exe_wreg = 1'b1; exe_wa = 5'd12;
        id_re2 = 1'b1; id_ra2 = 5'd12;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            #1;
            if (c == 4) begin
                checks++;
                if (perf_stall !== PERF_5) begin
                    errors++;
                    $display("FAIL perf_mid: got %0d expected %0d", perf_stall, PERF_5);
                end
            end
        end
        checks++;
        if (perf_stall !== PERF_20) begin
            errors++;
            $display("FAIL perf_saturate: got %0d expected %0d", perf_stall, PERF_20);
        end
        clear_inputs();
        do_reset();
        #1;
        checks++;
        if (perf_stall !== 4'd0) begin
            errors++;
            $display("FAIL perf_clear: got %0d expected 0", perf_stall);
        end
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_load_use();
        test_no_hazard();
        test_priority();
        test_div_normal();
        test_div_fast();
        test_div_timeout();
        test_reset_in_wait();
        test_perf();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
